// File: rtl/general_defines.sv
// Shared core widths and fetch-queue payload types.
package general_defines;

    localparam int unsigned INSTR_MEM_IDX_W = 32;
    localparam int unsigned INT_DATA_W      = 32;
    localparam int unsigned FQ_DEPTH        = 4;

    typedef struct packed {
        logic [INSTR_MEM_IDX_W-1:0] pc;
        logic [INT_DATA_W-1:0]      instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle around the fetch queue.
interface fetch_queue_if #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned CNT_W   = 3
);
    logic               flush;
    logic               if_valid;
    logic [PC_W-1:0]    if_pc;
    logic [INSTR_W-1:0] if_instr;
    logic               fq_stall;
    logic               id_valid;
    logic [PC_W-1:0]    id_pc;
    logic [INSTR_W-1:0] id_instr;
    logic               id_ready;
    logic [CNT_W-1:0]   fq_count;

    modport master (
        output flush, if_valid, if_pc, if_instr, id_ready,
        input  fq_stall, id_valid, id_pc, id_instr, fq_count
    );

    modport slave (
        input  flush, if_valid, if_pc, if_instr, id_ready,
        output fq_stall, id_valid, id_pc, id_instr, fq_count
    );
endinterface

// File: rtl/fetch_queue_ptr_ctr.sv
// Wrapping circular-buffer pointer with increment and clear.
module fq_ptr_ctr #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr_q
);
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO with flush; define FETCH_QUEUE_BYPASS_EN
// to let an empty queue forward the fetch entry to decode in the same cycle.
module fetch_queue
    import general_defines::*;
#(
    parameter int unsigned DEPTH   = FQ_DEPTH,
    parameter int unsigned PC_W    = INSTR_MEM_IDX_W,
    parameter int unsigned INSTR_W = INT_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  fq
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           wr_entry_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic             bypass_c, bypass_take_c, enq_c, deq_c;

    always_comb begin
        bypass_c = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_c = (count_q == '0) && fq.if_valid && !fq.flush && !rst;
`endif
        // A bypassed entry that decode takes immediately never touches storage.
        bypass_take_c = bypass_c && fq.id_ready;
        enq_c         = fq.if_valid && !full_q && !fq.flush && !bypass_take_c;
        deq_c         = (count_q != '0) && fq.id_ready && !fq.flush;
        wr_entry_d    = '{pc: fq.if_pc, instr: fq.if_instr};

        count_d = count_q;
        if (fq.flush) begin
            count_d = '0;
        end else if (enq_c && !deq_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (deq_c && !enq_c) begin
            count_d = count_q - CNT_W'(1);
        end
        // Stall is kept as its own flop so it never sees id_ready/if_valid.
        full_d = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_c && !rst) begin
            mem_q[wr_ptr_q] <= wr_entry_d;
        end
    end

    fq_ptr_ctr #(.W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (fq.flush),
        .inc   (deq_c),
        .ptr_q (rd_ptr_q)
    );

    fq_ptr_ctr #(.W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (fq.flush),
        .inc   (enq_c),
        .ptr_q (wr_ptr_q)
    );

    assign fq.fq_stall = full_q;
    assign fq.fq_count = count_q;
    assign fq.id_valid = (count_q != '0) || bypass_c;
    assign fq.id_pc    = bypass_c ? fq.if_pc    : mem_q[rd_ptr_q].pc;
    assign fq.id_instr = bypass_c ? fq.if_instr : mem_q[rd_ptr_q].instr;
endmodule

// File: tb/tb_fetch_queue.sv
// Table-driven bench for fetch_queue with an in-order data scoreboard.
module tb_fetch_queue;
    import general_defines::*;

    localparam int unsigned DEPTH   = FQ_DEPTH;
    localparam int unsigned PC_W    = INSTR_MEM_IDX_W;
    localparam int unsigned INSTR_W = INT_DATA_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    typedef struct {
        logic               r;
        logic               f;
        logic               v;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] ins;
        logic               rdy;
        logic               ev;
        logic               es;
        int                 ec;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    fq_entry_t sb[$];

    fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) fq_if ();

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic v, input logic [PC_W-1:0] pc,
                       input logic [INSTR_W-1:0] ins, input logic rdy,
                       input logic ev, input logic es, input int ec);
        vec_t t;
        t = '{r: r, f: f, v: v, pc: pc, ins: ins, rdy: rdy, ev: ev, es: es, ec: ec};
        vecs.push_back(t);
    endtask

    // One cycle: drive, check state outputs, settle scoreboard before the edge.
    task automatic step(input vec_t t);
        logic      byp;
        fq_entry_t e;
        @(negedge clk);
        rst               = t.r;
        fq_if.flush       = t.f;
        fq_if.if_valid    = t.v;
        fq_if.if_pc       = t.pc;
        fq_if.if_instr    = t.ins;
        fq_if.id_ready    = t.rdy;
        #1;
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (t.ec == 0) && t.v && !t.f && !t.r;
`endif
        check("id_valid", 64'(fq_if.id_valid), 64'(t.ev || byp));
        check("fq_stall", 64'(fq_if.fq_stall), 64'(t.es));
        check("fq_count", 64'(fq_if.fq_count), 64'(t.ec));
        if (byp) begin
            check("bypass_pc", 64'(fq_if.id_pc), 64'(t.pc));
            check("bypass_instr", 64'(fq_if.id_instr), 64'(t.ins));
            if (!t.rdy) sb.push_back('{pc: t.pc, instr: t.ins});
        end else begin
            if (t.ev && t.rdy && !t.f && !t.r) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("id_pc", 64'(fq_if.id_pc), 64'(e.pc));
                    check("id_instr", 64'(fq_if.id_instr), 64'(e.instr));
                end
            end
            if (t.v && !t.es && !t.f && !t.r) sb.push_back('{pc: t.pc, instr: t.ins});
        end
        if (t.f || t.r) sb.delete();
    endtask

    task automatic run_table();
        foreach (vecs[i]) step(vecs[i]);
        vecs.delete();
    endtask

    function automatic logic [INSTR_W-1:0] ins_of(input int pc);
        return INSTR_W'(pc) ^ INSTR_W'(32'h5A00_0000);
    endfunction

    initial begin
        vec_t t;
        rst            = 1'b1;
        fq_if.flush    = 1'b0;
        fq_if.if_valid = 1'b1;
        fq_if.if_pc    = '0;
        fq_if.if_instr = '0;
        fq_if.id_ready = 1'b0;
        @(posedge clk);

        // Reset held with if_valid, then first entry after reset.
        add(1, 0, 1, 'h99, 'h99, 1, 0, 0, 0);
        add(1, 0, 1, 'h98, 'h98, 1, 0, 0, 0);
        add(0, 0, 1, 'h10, 'hA,  0, 0, 0, 0);
        add(0, 0, 0, 0, 0,       1, 1, 0, 1);
        add(0, 0, 0, 0, 0,       0, 0, 0, 0);
        // Fill to full, pc=5 held, drain while full.
        for (int i = 1; i <= 4; i++) add(0, 0, 1, PC_W'(i), ins_of(i), 0, i > 1, 0, i - 1);
        add(0, 0, 1, 5, ins_of(5), 0, 1, 1, 4);
        add(0, 0, 1, 5, ins_of(5), 1, 1, 1, 4);
        add(0, 0, 1, 5, ins_of(5), 1, 1, 0, 3);
        add(0, 0, 0, 0, 0,         1, 1, 0, 3);
        add(0, 0, 0, 0, 0,         1, 1, 0, 2);
        add(0, 0, 0, 0, 0,         1, 1, 0, 1);
        add(0, 0, 0, 0, 0,         0, 0, 0, 0);
        // Flush with a dropped entry, then a fresh entry at head.
        add(0, 0, 1, 'h30, ins_of('h30), 0, 0, 0, 0);
        add(0, 0, 1, 'h31, ins_of('h31), 0, 1, 0, 1);
        add(0, 0, 1, 'h32, ins_of('h32), 0, 1, 0, 2);
        add(0, 1, 1, 'h33, ins_of('h33), 1, 1, 0, 3);
        add(0, 0, 1, 'h40, ins_of('h40), 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,               1, 1, 0, 1);
        add(0, 0, 0, 0, 0,               0, 0, 0, 0);
        // Reset mid-operation overrides enq/deq.
        add(0, 0, 1, 'h50, ins_of('h50), 0, 0, 0, 0);
        add(0, 0, 1, 'h51, ins_of('h51), 0, 1, 0, 1);
        add(1, 0, 1, 'h52, ins_of('h52), 1, 1, 0, 2);
        add(0, 0, 0, 0, 0,               1, 0, 0, 0);
        run_table();

        // Simultaneous enq/deq at count 2 across pointer wrap.
        add(0, 0, 1, 'h100, ins_of('h100), 0, 0, 0, 0);
        add(0, 0, 1, 'h101, ins_of('h101), 0, 1, 0, 1);
        run_table();
        for (int i = 0; i < 10; i++) begin
            t = '{r: 0, f: 0, v: 1, pc: PC_W'('h102 + i), ins: ins_of('h102 + i),
                  rdy: 1, ev: 1, es: 0, ec: 2};
            step(t);
        end
        add(0, 0, 0, 0, 0, 1, 1, 0, 2);
        add(0, 0, 0, 0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0);
        run_table();

        // Empty queue, entry presented with decode ready.
`ifdef FETCH_QUEUE_BYPASS_EN
        add(0, 0, 1, 'h20, ins_of('h20), 1, 1, 0, 0);
        add(0, 0, 0, 0, 0,               1, 0, 0, 0);
`else
        add(0, 0, 1, 'h20, ins_of('h20), 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,               1, 1, 0, 1);
        add(0, 0, 0, 0, 0,               1, 0, 0, 0);
`endif
        run_table();

        check("sb_empty_at_end", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
